// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB bus bundle for apb_cmd_master.
// The master modport is the controller side; slave is the environment side.
interface apb_cmd_master_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_write;
    logic [addrWidth-1:0] cmd_addr;
    logic [dataWidth-1:0] cmd_wdata;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [dataWidth-1:0] rsp_rdata;
    logic                 rsp_err;
    logic                 rsp_timeout;

    logic [addrWidth-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;
    logic                 pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, psel, penable, pwrite, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB master: one valid/ready command becomes one APB transfer, answered on the
// response handshake. A watchdog aborts transfers whose slave never asserts pready.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or watchdog expiry
// RESP   | bus released, rsp_valid held until rsp_ready
module apb_cmd_master #(
    parameter int addrWidth      = 32,
    parameter int dataWidth      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    apb_cmd_master_if.master  bus
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        wait_cnt, wait_cnt_nxt, wait_inc;
    logic [addrWidth-1:0] paddr_q, paddr_nxt;
    logic                 pwrite_q, pwrite_nxt;
    logic [dataWidth-1:0] pwdata_q, pwdata_nxt;
    logic                 psel_q, psel_nxt;
    logic                 penable_q, penable_nxt;
    logic                 rsp_valid_q, rsp_valid_nxt;
    logic [dataWidth-1:0] rsp_rdata_q, rsp_rdata_nxt;
    logic                 rsp_err_q, rsp_err_nxt;
    logic                 rsp_timeout_q, rsp_timeout_nxt;

    assign wait_inc = wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            paddr_q       <= paddr_nxt;
            pwrite_q      <= pwrite_nxt;
            pwdata_q      <= pwdata_nxt;
            psel_q        <= psel_nxt;
            penable_q     <= penable_nxt;
            rsp_valid_q   <= rsp_valid_nxt;
            rsp_rdata_q   <= rsp_rdata_nxt;
            rsp_err_q     <= rsp_err_nxt;
            rsp_timeout_q <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        paddr_nxt       = paddr_q;
        pwrite_nxt      = pwrite_q;
        pwdata_nxt      = pwdata_q;
        psel_nxt        = psel_q;
        penable_nxt     = penable_q;
        rsp_valid_nxt   = rsp_valid_q;
        rsp_rdata_nxt   = rsp_rdata_q;
        rsp_err_nxt     = rsp_err_q;
        rsp_timeout_nxt = rsp_timeout_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_nxt    = bus.cmd_addr;
                    pwrite_nxt   = bus.cmd_write;
                    pwdata_nxt   = bus.cmd_wdata;
                    psel_nxt     = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_nxt     = bus.pslverr;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    wait_cnt_nxt = wait_inc;
                    // this low-pready cycle is the last one the watchdog allows
                    if (wait_inc == CW'(TIMEOUT_CYCLES)) begin
                        psel_nxt        = 1'b0;
                        penable_nxt     = 1'b0;
                        rsp_valid_nxt   = 1'b1;
                        rsp_rdata_nxt   = '0;
                        rsp_err_nxt     = 1'b1;
                        rsp_timeout_nxt = 1'b1;
                        state_nxt       = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // gated by reset so cmd_ready is low while reset is held
    assign bus.cmd_ready   = (state == IDLE) && reset;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
